// File: rtl/count_seq_monitor.sv
// rtl/count_seq_monitor.sv - sequence monitor for an upstream 4-bit counter
//
// Purpose:
//   Watches the sampled value of a free-running 4-bit counter. After LOCK_N
//   consecutive correct increments the monitor is LOCKED. While LOCKED it
//   reports 15->0 wraps and flags any value that is not prev+1 as a
//   sequence error, then drops back to SYNC to re-acquire.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   cnt_in     - upstream counter value (4 bits)
//   sample_en  - cnt_in is sampled on this edge when high
//   err_clr    - synchronous clear of err_sticky / err_count
//   locked     - high while in LOCKED
//   wrap_pulse - one-cycle pulse after a LOCKED 15->0 sample
//   wrap_count - number of LOCKED wraps, modulo 2^WRAP_W
//   seq_err    - one-cycle pulse after a LOCKED sequence violation
//   err_sticky - set by any seq_err, cleared by err_clr
//   err_count  - saturating (max 15) count of seq_err events

module count_seq_monitor #(
  parameter int LOCK_N = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cnt_in,
  input  logic              sample_en,
  input  logic              err_clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              seq_err,
  output logic              err_sticky,
  output logic [3:0]        err_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_N);

  logic [1:0] state;
  logic [3:0] prev;
  logic [3:0] match;

  logic [3:0] prev_inc;
  logic [3:0] match_inc;
  logic       correct;
  logic       err_event;
  logic       wrap_event;

  // prev + 1 is kept at 4 bits so 15 -> 0 counts as a correct increment.
  assign prev_inc   = prev + 4'd1;
  assign match_inc  = match + 4'd1;
  assign correct    = (cnt_in == prev_inc);
  assign err_event  = sample_en && (state == LOCKED) && !correct;
  assign wrap_event = sample_en && (state == LOCKED) && correct &&
                      (prev == 4'd15) && (cnt_in == 4'd0);

  // Sequence FSM, prev/match registers and the event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev       <= 4'd0;
      match      <= 4'd0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      seq_err    <= 1'b0;
    end else begin
      wrap_pulse <= wrap_event;
      seq_err    <= err_event;
      if (wrap_event) begin
        wrap_count <= wrap_count + WRAP_W'(1);
      end
      if (sample_en) begin
        prev <= cnt_in;
        case (state)
          IDLE: begin
            match <= 4'd0;
            state <= SYNC;
          end
          SYNC: begin
            if (correct) begin
              match <= match_inc;
              if (match_inc == LOCK_TARGET) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match <= 4'd0;
            end
          end
          LOCKED: begin
            if (!correct) begin
              match  <= 4'd0;
              state  <= SYNC;
              locked <= 1'b0;
            end
          end
          default: begin
            match  <= 4'd0;
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Error bookkeeping. A new error on the same edge as err_clr wins and
  // restarts the count at 1 rather than being lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_count  <= 4'd0;
    end else if (err_event) begin
      err_sticky <= 1'b1;
      if (err_clr) begin
        err_count <= 4'd1;
      end else if (err_count != 4'd15) begin
        err_count <= err_count + 4'd1;
      end
    end else if (err_clr) begin
      err_sticky <= 1'b0;
      err_count  <= 4'd0;
    end
  end

endmodule
